// File: rtl/rob_multi_wb_if.sv
// Bundle of dispatch, writeback, commit and flush signals between the ROB and its neighbours.
// The ROB connects through the slave modport; dispatch/execute/retire logic uses master.
interface rob_multi_wb_if #(
  parameter int DEPTH  = 32,
  parameter int NUM_WB = 4,
  parameter int DATA_W = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                     enq_valid;
  logic                     enq_ready;
  logic [31:0]              enq_pc;
  logic [4:0]               enq_rd_addr;
  logic                     enq_regf_we;
  logic [IDX_W-1:0]         enq_idx;

  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*IDX_W-1:0]  wb_idx;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB-1:0]        wb_mispred;
  logic [NUM_WB*32-1:0]     wb_pc_new;

  logic                     commit_valid;
  logic                     commit_ready;
  logic [IDX_W-1:0]         commit_idx;
  logic [31:0]              commit_pc;
  logic [4:0]               commit_rd_addr;
  logic                     commit_regf_we;
  logic [DATA_W-1:0]        commit_data;

  logic                     flush_o;
  logic [31:0]              flush_pc;
  logic [IDX_W:0]           count_o;

  modport master (
    output enq_valid, enq_pc, enq_rd_addr, enq_regf_we,
    input  enq_ready, enq_idx,
    output wb_valid, wb_idx, wb_data, wb_mispred, wb_pc_new,
    input  commit_valid, commit_idx, commit_pc, commit_rd_addr, commit_regf_we, commit_data,
    output commit_ready,
    input  flush_o, flush_pc, count_o
  );

  modport slave (
    input  enq_valid, enq_pc, enq_rd_addr, enq_regf_we,
    output enq_ready, enq_idx,
    input  wb_valid, wb_idx, wb_data, wb_mispred, wb_pc_new,
    output commit_valid, commit_idx, commit_pc, commit_rd_addr, commit_regf_we, commit_data,
    input  commit_ready,
    output flush_o, flush_pc, count_o
  );
endinterface

// File: rtl/rob_multi_wb.sv
// Reorder buffer with NUM_WB index-addressed writeback ports, in-order single commit per cycle
// and a registered precise flush when a mispredicted branch retires.
module rob_multi_wb #(
  parameter int DEPTH  = 32,
  parameter int NUM_WB = 4,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  rob_multi_wb_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   ONE_CNT  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_DONE} state_e;

  state_e           state_q [DEPTH];
  state_e           state_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  // Payload storage carries no reset; the state array alone decides what is meaningful.
  logic [31:0]       pc_q      [DEPTH];
  logic [4:0]        rd_q      [DEPTH];
  logic              we_q      [DEPTH];
  logic [DATA_W-1:0] data_q    [DEPTH];
  logic              mispred_q [DEPTH];
  logic [31:0]       pcnew_q   [DEPTH];

  logic [IDX_W-1:0]  wb_idx_a   [NUM_WB];
  logic [DATA_W-1:0] wb_data_a  [NUM_WB];
  logic [31:0]       wb_pcnew_a [NUM_WB];

  for (genvar g = 0; g < NUM_WB; g++) begin : g_wb_split
    assign wb_idx_a[g]   = bus.wb_idx[g*IDX_W +: IDX_W];
    assign wb_data_a[g]  = bus.wb_data[g*DATA_W +: DATA_W];
    assign wb_pcnew_a[g] = bus.wb_pc_new[g*32 +: 32];
  end

  logic enq_ready, enq_fire, commit_valid, commit_fire, flush_take;

  assign enq_ready    = (count_q != FULL_CNT);
  assign enq_fire     = bus.enq_valid & enq_ready;
  assign commit_valid = (state_q[head_q] == ST_DONE);
  assign commit_fire  = commit_valid & bus.commit_ready;
  assign flush_take   = commit_fire & mispred_q[head_q];

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    if (flush_take) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = ST_EMPTY;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = pcnew_q[head_q];
    end else begin
      // Writeback only promotes WAIT entries, so it never collides with enqueue or commit slots.
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.wb_valid[p] && state_q[wb_idx_a[p]] == ST_WAIT) state_d[wb_idx_a[p]] = ST_DONE;
      end
      if (commit_fire) begin
        state_d[head_q] = ST_EMPTY;
        head_d          = head_q + ONE_IDX;
      end
      if (enq_fire) begin
        state_d[tail_q] = ST_WAIT;
        tail_d          = tail_q + ONE_IDX;
      end
      case ({enq_fire, commit_fire})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Later ports overwrite earlier ones on a shared index, giving the highest port priority.
  always_ff @(posedge clk) begin
    if (!flush_take) begin
      if (enq_fire) begin
        pc_q[tail_q] <= bus.enq_pc;
        rd_q[tail_q] <= bus.enq_rd_addr;
        we_q[tail_q] <= bus.enq_regf_we;
      end
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.wb_valid[p] && state_q[wb_idx_a[p]] == ST_WAIT) begin
          data_q[wb_idx_a[p]]    <= wb_data_a[p];
          mispred_q[wb_idx_a[p]] <= bus.wb_mispred[p];
          pcnew_q[wb_idx_a[p]]   <= wb_pcnew_a[p];
        end
      end
    end
  end

  assign bus.enq_ready      = enq_ready;
  assign bus.enq_idx        = tail_q;
  assign bus.commit_valid   = commit_valid;
  assign bus.commit_idx     = head_q;
  assign bus.commit_pc      = pc_q[head_q];
  assign bus.commit_rd_addr = rd_q[head_q];
  assign bus.commit_regf_we = we_q[head_q];
  assign bus.commit_data    = data_q[head_q];
  assign bus.flush_o        = flush_q;
  assign bus.flush_pc       = flush_pc_q;
  assign bus.count_o        = count_q;
endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed bench for rob_multi_wb: a negedge scoreboard tracks expected entry state and commit
// order while a linear sequence drives the scenarios and checks their headline values.
module tb_rob_multi_wb;
  localparam int DEPTH = 32;
  localparam int NWB   = 4;
  localparam int IW    = 5;

  logic clk, rst;
  rob_multi_wb_if #(.DEPTH(DEPTH), .NUM_WB(NWB), .DATA_W(32)) bus ();
  rob_multi_wb #(.DEPTH(DEPTH), .NUM_WB(NWB), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        sbq[$];
  int          mstate [DEPTH];
  int          msnap  [DEPTH];
  logic [31:0] mdata  [DEPTH];
  logic        mmis   [DEPTH];
  logic [31:0] mpcn   [DEPTH];
  int          mtail, mcount;
  logic        mflush;
  logic [31:0] mflush_pc;
  exp_t        m_e;
  logic        m_cv, m_fire, m_enq_ok;
  int          m_wi;

  // Scoreboard: check outputs against the model, then advance the model by the inputs seen.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      for (int i = 0; i < DEPTH; i++) mstate[i] = 0;
      mtail = 0; mcount = 0; mflush = 1'b0; mflush_pc = '0;
    end else begin
      m_enq_ok = (mcount != DEPTH);
      chk("enq_ready", bus.enq_ready, m_enq_ok);
      chk("count_o", bus.count_o, mcount);
      chk("enq_idx", bus.enq_idx, mtail);
      m_cv = (sbq.size() != 0) && (mstate[sbq[0].idx] == 2);
      chk("commit_valid", bus.commit_valid, m_cv);
      chk("flush_o", bus.flush_o, mflush);
      if (mflush) chk("flush_pc", bus.flush_pc, mflush_pc);
      m_fire = m_cv && bus.commit_ready;
      if (m_fire) begin
        m_e = sbq[0];
        chk("commit_idx", bus.commit_idx, m_e.idx);
        chk("commit_pc", bus.commit_pc, m_e.pc);
        chk("commit_rd", bus.commit_rd_addr, m_e.rd);
        chk("commit_we", bus.commit_regf_we, m_e.we);
        chk("commit_data", bus.commit_data, mdata[m_e.idx]);
      end
      msnap = mstate;
      if (m_fire && mmis[m_e.idx]) begin
        mflush = 1'b1; mflush_pc = mpcn[m_e.idx];
        sbq.delete();
        for (int i = 0; i < DEPTH; i++) mstate[i] = 0;
        mtail = 0; mcount = 0;
      end else begin
        mflush = 1'b0;
        for (int p = 0; p < NWB; p++) begin
          m_wi = int'(bus.wb_idx[p*IW +: IW]);
          if (bus.wb_valid[p] && msnap[m_wi] == 1) begin
            mstate[m_wi] = 2;
            mdata[m_wi]  = bus.wb_data[p*32 +: 32];
            mmis[m_wi]   = bus.wb_mispred[p];
            mpcn[m_wi]   = bus.wb_pc_new[p*32 +: 32];
          end
        end
        if (m_fire) begin
          mstate[m_e.idx] = 0;
          void'(sbq.pop_front());
          mcount--;
        end
        if (bus.enq_valid && m_enq_ok) begin
          mstate[mtail] = 1;
          sbq.push_back('{idx: mtail, pc: bus.enq_pc, rd: bus.enq_rd_addr, we: bus.enq_regf_we});
          mtail = (mtail + 1) % DEPTH;
          mcount++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [4:0] rd, input logic we);
    bus.enq_valid = 1'b1; bus.enq_pc = pc; bus.enq_rd_addr = rd; bus.enq_regf_we = we;
    tick();
    bus.enq_valid = 1'b0;
  endtask

  task automatic wb(input int p, input int idx, input logic [31:0] d, input logic mis,
                    input logic [31:0] pcn);
    bus.wb_valid[p]            = 1'b1;
    bus.wb_idx[p*IW +: IW]     = IW'(idx);
    bus.wb_data[p*32 +: 32]    = d;
    bus.wb_mispred[p]          = mis;
    bus.wb_pc_new[p*32 +: 32]  = pcn;
  endtask

  task automatic wb_go();
    tick();
    bus.wb_valid = '0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && bus.count_o != 0; i++) tick();
    chk("drain_count", bus.count_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_rd_addr = '0; bus.enq_regf_we = 1'b0;
    bus.wb_valid = '0; bus.wb_idx = '0; bus.wb_data = '0; bus.wb_mispred = '0; bus.wb_pc_new = '0;
    bus.commit_ready = 1'b0;

    tick();
    chk("rst_count", bus.count_o, 0);
    chk("rst_commit_valid", bus.commit_valid, 0);
    chk("rst_enq_ready", bus.enq_ready, 1);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_flush_pc", bus.flush_pc, 0);
    tick();
    rst = 1'b0;

    // 1: out-of-order writeback, in-order commit
    bus.commit_ready = 1'b1;
    enq(32'h100, 5'd1, 1'b1);
    enq(32'h104, 5'd2, 1'b1);
    enq(32'h108, 5'd3, 1'b0);
    chk("t1_count3", bus.count_o, 3);
    wb(0, 1, 32'hA1, 1'b0, '0); wb_go();
    chk("t1_head_wait", bus.commit_valid, 0);
    wb(1, 0, 32'hA0, 1'b0, '0); wb_go();
    chk("t1_head_done", bus.commit_valid, 1);
    wb(2, 2, 32'hA2, 1'b0, '0); wb_go();
    drain(8);

    // 2: fill, full blocks enqueue even with commit, then wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(32'h2000 + 32'(i*4), 5'(i), 1'b1);
    chk("t2_full_ready", bus.enq_ready, 0);
    chk("t2_full_count", bus.count_o, 32);
    chk("t2_full_tail", bus.enq_idx, 0);
    wb(0, 0, 32'hB0, 1'b0, '0); wb_go();
    bus.commit_ready = 1'b1;
    bus.enq_valid = 1'b1; bus.enq_pc = 32'h3000; bus.enq_rd_addr = 5'd9; bus.enq_regf_we = 1'b1;
    tick();
    bus.commit_ready = 1'b0;
    chk("t2_after_commit_count", bus.count_o, 31);
    chk("t2_after_commit_idx", bus.enq_idx, 0);
    tick();
    bus.enq_valid = 1'b0;
    chk("t2_wrap_count", bus.count_o, 32);
    chk("t2_wrap_idx", bus.enq_idx, 1);

    // 3: same-index writeback priority, late writeback ignored
    do_reset();
    for (int i = 0; i < 6; i++) enq(32'h400 + 32'(i*4), 5'(i+1), 1'b1);
    wb(0, 5, 32'hAAAA_0000, 1'b0, '0);
    wb(3, 5, 32'hBBBB_0000, 1'b0, '0);
    wb_go();
    wb(1, 5, 32'hCCCC_0000, 1'b0, '0); wb_go();
    for (int p = 0; p < 4; p++) wb(p, p, 32'h30 + 32'(p), 1'b0, '0);
    wb_go();
    wb(2, 4, 32'h34, 1'b0, '0); wb_go();
    bus.commit_ready = 1'b1;
    for (int i = 0; i < 10 && !(bus.commit_valid && bus.commit_idx == 5); i++) tick();
    chk("t3_head5_valid", bus.commit_valid, 1);
    chk("t3_prio_data", bus.commit_data, 32'hBBBB_0000);
    drain(8);

    // 4: mispredicted branch retire flushes everything
    do_reset();
    bus.commit_ready = 1'b1;
    for (int i = 0; i < 5; i++) enq(32'h500 + 32'(i*4), 5'(i+1), 1'b1);
    wb(0, 0, 32'hD0, 1'b0, '0);
    wb(1, 1, 32'hD1, 1'b0, '0);
    wb_go();
    wb(3, 2, 32'hD2, 1'b1, 32'h1000_0040); wb_go();
    for (int i = 0; i < 8 && !bus.flush_o; i++) tick();
    chk("t4_flush", bus.flush_o, 1);
    chk("t4_flush_pc", bus.flush_pc, 32'h1000_0040);
    chk("t4_count", bus.count_o, 0);
    chk("t4_enq_idx", bus.enq_idx, 0);
    chk("t4_commit_valid", bus.commit_valid, 0);
    wb(0, 3, 32'hD3, 1'b0, '0); wb_go();
    chk("t4_flush_pulse", bus.flush_o, 0);
    chk("t4_stale_wb", bus.commit_valid, 0);

    // 5: stalled commit keeps head, enqueue fills behind it
    do_reset();
    bus.commit_ready = 1'b0;
    enq(32'h600, 5'd7, 1'b1);
    wb(0, 0, 32'hE0, 1'b0, '0); wb_go();
    for (int i = 1; i < DEPTH; i++) enq(32'h600 + 32'(i*4), 5'(i), 1'b0);
    chk("t5_valid", bus.commit_valid, 1);
    chk("t5_head", bus.commit_idx, 0);
    chk("t5_count", bus.count_o, 32);
    chk("t5_ready", bus.enq_ready, 0);
    tick();
    chk("t5_head_hold", bus.commit_idx, 0);
    bus.commit_ready = 1'b1;
    for (int k = 1; k < DEPTH; k += 4) begin
      for (int p = 0; p < 4; p++) if (k + p < DEPTH) wb(p, k + p, $urandom, 1'b0, '0);
      wb_go();
    end
    drain(64);

    // 6: asynchronous reset mid-cycle
    do_reset();
    bus.commit_ready = 1'b0;
    for (int i = 0; i < 10; i++) enq(32'h700 + 32'(i*4), 5'(i), 1'b1);
    wb(0, 0, 32'hF0, 1'b0, '0); wb_go();
    chk("t6_count10", bus.count_o, 10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_count", bus.count_o, 0);
    chk("t6_async_valid", bus.commit_valid, 0);
    chk("t6_async_ready", bus.enq_ready, 1);
    chk("t6_async_flush", bus.flush_o, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_after_count", bus.count_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
